// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches two operands from memory, runs one ALU operation,
// optionally writes the result back, then pulses o_done. All outputs are registered.
module alu_sequencer #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OP_W   = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [ADDR_W-1:0] i_addr_dst,
   input  logic [OP_W-1:0]   i_opcode,
   input  logic              i_write_back,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_result_out,
   output logic              o_carry_out,
   output logic              o_mem_we,
   output logic              o_mem_re,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_in,
   input  logic [DATA_W-1:0] i_mem_out,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic [OP_W-1:0]   o_alu_opcode,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic              i_alu_carry
);

   typedef enum logic [2:0] {
      StIdle, StRdA, StLatA, StRdB, StLatB, StExec, StWr, StDone
   } state_e;

   state_e            r_state;
   logic [ADDR_W-1:0] r_addr_b;
   logic [ADDR_W-1:0] r_addr_dst;
   logic [OP_W-1:0]   r_opcode;
   logic              r_write_back;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic              r_busy;
   logic              r_done;
   logic [DATA_W-1:0] r_result;
   logic              r_carry;
   logic              r_mem_we;
   logic              r_mem_re;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_in;

   // Memory strobes and address/data are set on the edge entering the access state
   // and default back to zero, so they are zero in every non-access state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_addr_b     <= '0;
         r_addr_dst   <= '0;
         r_opcode     <= '0;
         r_write_back <= 1'b0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_result     <= '0;
         r_carry      <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_re     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_in     <= '0;
      end else begin
         r_done     <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_re   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_in   <= '0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_addr_b     <= i_addr_b;
                  r_addr_dst   <= i_addr_dst;
                  r_opcode     <= i_opcode;
                  r_write_back <= i_write_back;
                  r_busy       <= 1'b1;
                  r_mem_re     <= 1'b1;
                  r_mem_addr   <= i_addr_a;
                  r_state      <= StRdA;
               end
            end
            StRdA: r_state <= StLatA;
            StLatA: begin
               r_op_a     <= i_mem_out;
               r_mem_re   <= 1'b1;
               r_mem_addr <= r_addr_b;
               r_state    <= StRdB;
            end
            StRdB: r_state <= StLatB;
            StLatB: begin
               r_op_b  <= i_mem_out;
               r_state <= StExec;
            end
            StExec: begin
               r_result <= i_alu_result;
               r_carry  <= i_alu_carry;
               if (r_write_back) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= r_addr_dst;
                  r_mem_in   <= i_alu_result;
                  r_state    <= StWr;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
            StWr: begin
               r_done  <= 1'b1;
               r_state <= StDone;
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_result_out = r_result;
   assign o_carry_out  = r_carry;
   assign o_mem_we     = r_mem_we;
   assign o_mem_re     = r_mem_re;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_in     = r_mem_in;
   assign o_alu_a      = r_op_a;
   assign o_alu_b      = r_op_b;
   assign o_alu_opcode = r_opcode;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural memory and ALU, directed commands, and a
// scoreboard monitor that checks result, carry and completion cycle on every done pulse.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] addr_a = '0, addr_b = '0, addr_dst = '0;
   logic [3:0]  opcode = '0;
   logic        write_back = 1'b0;
   logic        busy, done, carry_out, mem_we, mem_re, alu_carry;
   logic [7:0]  result_out, mem_in, alu_a, alu_b, alu_result;
   logic [7:0]  mem_out = '0;
   logic [11:0] mem_addr;
   logic [3:0]  alu_opcode;

   logic [7:0]  mem [4096];
   logic        pl_we = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;
   int          we_cnt = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   typedef struct {
      logic [7:0] res;
      logic       c;
      int         cyc;
      string      name;
   } exp_t;
   exp_t sb[$];

   alu_sequencer #(.ADDR_W(12), .DATA_W(8), .OP_W(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .i_addr_a(addr_a), .i_addr_b(addr_b), .i_addr_dst(addr_dst),
      .i_opcode(opcode), .i_write_back(write_back),
      .o_busy(busy), .o_done(done), .o_result_out(result_out), .o_carry_out(carry_out),
      .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr), .o_mem_in(mem_in),
      .i_mem_out(mem_out), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_opcode(alu_opcode),
      .i_alu_result(alu_result), .i_alu_carry(alu_carry)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: synchronous write, registered read on edges where re is high.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      if (mem_we) begin
         mem[mem_addr] <= mem_in;
         we_cnt <= we_cnt + 1;
      end
      if (mem_re) mem_out <= mem[mem_addr];
   end

   // ALU stand-in: 0 add, 1 subtract (carry = borrow), 2 and, 3 xor.
   always_comb begin
      {alu_carry, alu_result} = 9'h000;
      case (alu_opcode)
         4'h0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
         4'h1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
         4'h2: alu_result = alu_a & alu_b;
         4'h3: alu_result = alu_a ^ alu_b;
         default: {alu_carry, alu_result} = 9'h000;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (mem_we && mem_re) check("we_re_exclusive", 32'(1), 32'(0));
         if (!mem_we && !mem_re && (mem_addr != 12'h0 || mem_in != 8'h0))
            check("idle_addr_data_zero", 32'({mem_addr, mem_in}), 32'(0));
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check({e.name, "_result"}, 32'(result_out), 32'(e.res));
               check({e.name, "_carry"}, 32'(carry_out), 32'(e.c));
               check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_we = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      for (int i = 0; i < max && busy; i++) @(negedge clk);
      check({name, "_idle"}, 32'(busy), 32'(0));
   endtask

   task automatic issue(input string name, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] dst, input logic [3:0] op, input logic wb,
                        input logic [7:0] er, input logic ec);
      exp_t e;
      @(negedge clk);
      addr_a = a;
      addr_b = b;
      addr_dst = dst;
      opcode = op;
      write_back = wb;
      start = 1'b1;
      @(posedge clk);
      #1;
      e.res = er;
      e.c = ec;
      e.cyc = cyc + (wb ? 6 : 5);
      e.name = name;
      sb.push_back(e);
      start = 1'b0;
      check({name, "_busy_from_e0"}, 32'(busy), 32'(1));
   endtask

   int we_before;
   int done_before;
   int c0;
   exp_t e2;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_we_re", 32'({mem_we, mem_re}), 32'(0));
      check("rst_addr_in", 32'({mem_addr, mem_in}), 32'(0));
      check("rst_result_carry", 32'({result_out, carry_out}), 32'(0));
      check("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'(0));
      reset = 1'b0;

      preload(12'h000, 8'h01);
      preload(12'h800, 8'h02);
      issue("add_basic", 12'h000, 12'h800, 12'h001, 4'h0, 1'b1, 8'h03, 1'b0);
      wait_idle("add_basic", 20);
      check("add_basic_mem", 32'(mem[12'h001]), 32'(8'h03));

      preload(12'h010, 8'hFF);
      preload(12'h011, 8'h01);
      issue("add_carry", 12'h010, 12'h011, 12'h012, 4'h0, 1'b1, 8'h00, 1'b1);
      wait_idle("add_carry", 20);
      check("add_carry_mem", 32'(mem[12'h012]), 32'(8'h00));

      preload(12'h020, 8'h55);
      preload(12'h030, 8'h10);
      preload(12'h031, 8'h20);
      we_before = we_cnt;
      issue("no_wb", 12'h030, 12'h031, 12'h020, 4'h0, 1'b0, 8'h30, 1'b0);
      wait_idle("no_wb", 20);
      check("no_wb_we_count", 32'(we_cnt), 32'(we_before));
      check("no_wb_mem", 32'(mem[12'h020]), 32'(8'h55));

      preload(12'h100, 8'h04);
      issue("same_addr", 12'h100, 12'h100, 12'h100, 4'h0, 1'b1, 8'h08, 1'b0);
      wait_idle("same_addr", 20);
      check("same_addr_mem", 32'(mem[12'h100]), 32'(8'h08));

      preload(12'h200, 8'h05);
      preload(12'h201, 8'h07);
      issue("sub_borrow", 12'h200, 12'h201, 12'h202, 4'h1, 1'b1, 8'hFE, 1'b1);
      wait_idle("sub_borrow", 20);
      check("sub_borrow_mem", 32'(mem[12'h202]), 32'(8'hFE));

      preload(12'h203, 8'hF0);
      preload(12'h204, 8'h3C);
      issue("and_nowb", 12'h203, 12'h204, 12'h205, 4'h2, 1'b0, 8'h30, 1'b0);
      wait_idle("and_nowb", 20);

      // Abort during RD_B: no expectation is queued, so any done pulse is flagged.
      preload(12'h300, 8'hAA);
      preload(12'h040, 8'h11);
      preload(12'h041, 8'h22);
      we_before = we_cnt;
      done_before = done_cnt;
      @(negedge clk);
      addr_a = 12'h040;
      addr_b = 12'h041;
      addr_dst = 12'h300;
      opcode = 4'h0;
      write_back = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_re_addr", 32'({mem_re, mem_addr}), 32'(0));
      check("abort_result", 32'({result_out, carry_out}), 32'(0));
      check("abort_alu", 32'({alu_a, alu_b, alu_opcode}), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'(done_before));
      check("abort_no_write", 32'(we_cnt), 32'(we_before));
      check("abort_mem", 32'(mem[12'h300]), 32'(8'hAA));

      issue("after_abort", 12'h040, 12'h041, 12'h300, 4'h0, 1'b1, 8'h33, 1'b0);
      wait_idle("after_abort", 20);
      check("after_abort_mem", 32'(mem[12'h300]), 32'(8'h33));

      // start held high across two commands: second accept must land 8 edges later.
      preload(12'h050, 8'h21);
      preload(12'h051, 8'h12);
      preload(12'h060, 8'h80);
      preload(12'h061, 8'h80);
      @(negedge clk);
      addr_a = 12'h050;
      addr_b = 12'h051;
      addr_dst = 12'h052;
      opcode = 4'h0;
      write_back = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 c0 = cyc;
      e2.res = 8'h33;
      e2.c = 1'b0;
      e2.cyc = c0 + 6;
      e2.name = "held_1";
      sb.push_back(e2);
      e2.res = 8'h00;
      e2.c = 1'b1;
      e2.cyc = c0 + 14;
      e2.name = "held_2";
      sb.push_back(e2);
      addr_a = 12'h060;
      addr_b = 12'h061;
      addr_dst = 12'h062;
      repeat (8) @(posedge clk);
      #1 start = 1'b0;
      check("held_2_busy", 32'(busy), 32'(1));
      wait_idle("held", 20);
      check("held_1_mem", 32'(mem[12'h052]), 32'(8'h33));
      check("held_2_mem", 32'(mem[12'h062]), 32'(8'h00));

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
